// File: rtl/jtag_ir_decoder.sv
// jtag_ir_decoder: IEEE 1149.1 instruction register with capture, shift and
// update stages. TDO, TDO enable and the update stage are driven from the
// falling edge of tck. The latched opcode is decoded into one-hot
// data-register selects. Unknown opcodes and the all-ones opcode select BYPASS.
// Optional feature macro: IR_CAPTURE_STATUS_EN. When it is defined,
// Capture-IR loads {status, 2'b01} instead of {0..., 2'b01}.
module jtag_ir_decoder #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned IDCODE_OP = 1,
   parameter int unsigned USER_BASE = 8,
   parameter int unsigned NUM_USER  = 2
) (
   input  logic                tck,
   input  logic                tl_reset,
   input  logic                tdi,
   input  logic                CaptureIR,
   input  logic                ShiftIR,
   input  logic                UpdateIR,
   input  logic [WIDTH-3:0]    status,
   output logic                tdo,
   output logic                tdo_en,
   output logic [WIDTH-1:0]    instruction,
   output logic                bypass_sel,
   output logic                idcode_sel,
   output logic [NUM_USER-1:0] user_sel
);

   localparam logic [WIDTH-1:0] IDCODE_V = WIDTH'(IDCODE_OP);
   localparam logic [WIDTH-1:0] RESET_SR = WIDTH'(1);
   // The user range is compared one bit wider so that its top cannot wrap.
   localparam logic [WIDTH:0]   UB       = (WIDTH+1)'(USER_BASE);
   localparam logic [WIDTH:0]   UT       = UB + (WIDTH+1)'(NUM_USER);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic             tdo_q, tdo_en_q;
   logic [WIDTH-3:0] cap_upper;

`ifdef IR_CAPTURE_STATUS_EN
   assign cap_upper = status;
`else
   assign cap_upper = '0;
   logic unused_status;
   assign unused_status = ^status;
`endif

   // Shift-stage next state: capture has priority over shift; otherwise hold.
   always_comb begin
      sr_d = sr_q;
      if (CaptureIR)
         sr_d = {cap_upper, 2'b01};
      else if (ShiftIR)
         sr_d = {tdi, sr_q[WIDTH-1:1]};
   end

   // Shift stage register, rising tck.
   always_ff @(posedge tck or posedge tl_reset) begin
      if (tl_reset) sr_q <= RESET_SR;
      else          sr_q <= sr_d;
   end

   // The update stage follows the shift stage only in Update-IR.
   always_comb begin
      instr_d = instr_q;
      if (UpdateIR) instr_d = sr_q;
   end

   // Falling-edge state: the update stage and the TDO drivers.
   always_ff @(negedge tck or posedge tl_reset) begin
      if (tl_reset) begin
         instr_q  <= IDCODE_V;
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         instr_q  <= instr_d;
         tdo_q    <= sr_q[0];
         tdo_en_q <= ShiftIR;
      end
   end

   assign instruction = instr_q;
   assign tdo         = tdo_q;
   assign tdo_en      = tdo_en_q;

   // Decode. The all-ones opcode is forced to BYPASS even if a parameter
   // overlaps it, and BYPASS takes every leftover code so that exactly one
   // select is high at all times.
   logic [WIDTH:0] instr_ext, user_off;
   logic           all_ones, is_id, in_user;

   // Combinational opcode classification.
   always_comb begin
      instr_ext = {1'b0, instr_q};
      user_off  = instr_ext - UB;
      all_ones  = &instr_q;
      is_id     = (instr_q == IDCODE_V) && !all_ones;
      in_user   = !all_ones && !is_id && (instr_ext >= UB) && (instr_ext < UT);
   end

   genvar k;
   generate
      for (k = 0; k < NUM_USER; k++) begin : g_user
         assign user_sel[k] = in_user && (user_off == (WIDTH+1)'(k));
      end
   endgenerate

   assign idcode_sel = is_id;
   assign bypass_sel = !is_id && !in_user;

endmodule
